// File: rtl/pa_pkg.sv
// Shared parser/scheduler types: parsed instruction record, scheduler state
// encoding and the widths used across the front end.
package pa_pkg;
  localparam int NUM_REGS     = 32;
  localparam int REG_W        = 5;
  localparam int OPCODE_W     = 7;
  localparam int OPERAND_W    = 16;
  localparam int MAX_INFLIGHT = 4;
  localparam int INFLIGHT_W   = 3;

  localparam logic [INFLIGHT_W-1:0] MAX_INF = INFLIGHT_W'(MAX_INFLIGHT);

  typedef enum logic {
    IDLE        = 1'b0,
    BRANCH_WAIT = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic                 format;
    logic                 is_branch;
    logic [OPCODE_W-1:0]  opcode;
    logic [REG_W-1:0]     prim;
    logic [OPERAND_W-1:0] sec;
  } parsed_instr_t;

  // In the 19-bit format the secondary operand names a register in its low bits.
  function automatic logic [REG_W-1:0] sec_reg(input parsed_instr_t instr);
    return instr.sec[REG_W-1:0];
  endfunction
endpackage

// File: rtl/sched_scoreboard.sv
// Register busy vector: one set and one clear port per cycle (set wins on a
// collision) and two combinational read ports for hazard lookup.
module sched_scoreboard
  import pa_pkg::*;
(
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                set_en_i,
  input  logic [REG_W-1:0]    set_idx_i,
  input  logic                clr_en_i,
  input  logic [REG_W-1:0]    clr_idx_i,
  input  logic [REG_W-1:0]    rd_a_idx_i,
  input  logic [REG_W-1:0]    rd_b_idx_i,
  output logic                rd_a_o,
  output logic                rd_b_o,
  output logic [NUM_REGS-1:0] busy_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign rd_a_o = busy_q[rd_a_idx_i];
  assign rd_b_o = busy_q[rd_b_idx_i];
  assign busy_o = busy_q;
endmodule

// File: rtl/issue_scheduler.sv
// Single-entry hold stage between Parser and execute: hazard check against the
// busy scoreboard, issue slot, writer-inflight limit and branch serialisation.
//
// Issue handshake: a slot transfers on a clock edge where issueValid_o and
// issueReady_i are both high; while issueValid_o is high and issueReady_i is
// low the slot and all issue fields hold steady. Parser side: an instruction
// is taken on an edge where enable_i is high and shouldStalled_o is low.
module issue_scheduler
  import pa_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  format_i,
  input  logic                  isBranch_i,
  input  logic [OPCODE_W-1:0]   opcode_i,
  input  logic [REG_W-1:0]      primOperand_i,
  input  logic [OPERAND_W-1:0]  secOperand_i,
  output logic                  shouldStalled_o,
  output logic                  issueValid_o,
  input  logic                  issueReady_i,
  output logic                  issueFormat_o,
  output logic                  issueBranch_o,
  output logic [OPCODE_W-1:0]   issueOpcode_o,
  output logic [REG_W-1:0]      issuePrim_o,
  output logic [OPERAND_W-1:0]  issueSec_o,
  input  logic                  wbValid_i,
  input  logic [REG_W-1:0]      wbReg_i,
  input  logic                  branchResolved_i,
  output sched_state_t          dbg_state_o,
  output logic [NUM_REGS-1:0]   dbg_busy_o,
  output logic [INFLIGHT_W-1:0] dbg_inflight_o
);
  sched_state_t            state_q, state_d;
  logic                    hold_valid_q, hold_valid_d;
  parsed_instr_t           hold_q, hold_d;
  logic                    issue_valid_q, issue_valid_d;
  parsed_instr_t           issue_q, issue_d;
  logic [INFLIGHT_W-1:0]   inflight_q, inflight_d;

  parsed_instr_t in_instr;
  logic prim_busy, sec_busy, hazard, slot_free, issue_fire, writer_fire;
  logic stall, hold_load;

  assign in_instr = '{format: format_i, is_branch: isBranch_i, opcode: opcode_i,
                      prim: primOperand_i, sec: secOperand_i};

  sched_scoreboard u_scoreboard (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .set_en_i   (writer_fire),
    .set_idx_i  (hold_q.prim),
    .clr_en_i   (wbValid_i),
    .clr_idx_i  (wbReg_i),
    .rd_a_idx_i (hold_q.prim),
    .rd_b_idx_i (sec_reg(hold_q)),
    .rd_a_o     (prim_busy),
    .rd_b_o     (sec_busy),
    .busy_o     (dbg_busy_o)
  );

  // Hazards read the registered scoreboard only; a same-cycle writeback is not bypassed.
  always_comb begin
    hazard      = prim_busy | (!hold_q.format & sec_busy);
    slot_free   = !issue_valid_q | issueReady_i;
    issue_fire  = hold_valid_q & !hazard & slot_free & (state_q == IDLE) &
                  (hold_q.is_branch | (inflight_q < MAX_INF));
    writer_fire = issue_fire & !hold_q.is_branch;
    stall       = (state_q == BRANCH_WAIT) | (hold_valid_q & !issue_fire) |
                  (hold_valid_q & hold_q.is_branch);
    hold_load   = enable_i & !stall;
  end

  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_d        = hold_q;
    issue_valid_d = issue_valid_q;
    issue_d       = issue_q;
    if (issue_fire) hold_valid_d = 1'b0;
    if (hold_load) begin
      hold_valid_d = 1'b1;
      hold_d       = in_instr;
    end
    if (issue_fire) begin
      issue_valid_d = 1'b1;
      issue_d       = hold_q;
    end else if (issueReady_i) begin
      issue_valid_d = 1'b0;
    end
  end

  // Counter cannot exceed MAX_INF (fire is gated on it) nor drop below zero.
  always_comb begin
    inflight_d = inflight_q;
    if (writer_fire && !wbValid_i && inflight_q != MAX_INF)
      inflight_d = inflight_q + INFLIGHT_W'(1);
    else if (!writer_fire && wbValid_i && inflight_q != '0)
      inflight_d = inflight_q - INFLIGHT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (issue_fire && hold_q.is_branch) state_d = BRANCH_WAIT;
      BRANCH_WAIT: if (branchResolved_i) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      hold_valid_q  <= 1'b0;
      hold_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
      inflight_q    <= '0;
    end else begin
      state_q       <= state_d;
      hold_valid_q  <= hold_valid_d;
      hold_q        <= hold_d;
      issue_valid_q <= issue_valid_d;
      issue_q       <= issue_d;
      inflight_q    <= inflight_d;
    end
  end

  assign shouldStalled_o = stall;
  assign issueValid_o    = issue_valid_q;
  assign issueFormat_o   = issue_q.format;
  assign issueBranch_o   = issue_q.is_branch;
  assign issueOpcode_o   = issue_q.opcode;
  assign issuePrim_o     = issue_q.prim;
  assign issueSec_o      = issue_q.sec;
  assign dbg_state_o     = state_q;
  assign dbg_inflight_o  = inflight_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed vector table, corner-case sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_issue_scheduler;
  import pa_pkg::*;

  localparam int IW = $bits(parsed_instr_t);

  logic                  clock_i = 1'b0;
  logic                  reset_i;
  logic                  enable_i, format_i, isBranch_i;
  logic [OPCODE_W-1:0]   opcode_i;
  logic [REG_W-1:0]      primOperand_i;
  logic [OPERAND_W-1:0]  secOperand_i;
  logic                  shouldStalled_o, issueValid_o, issueReady_i;
  logic                  issueFormat_o, issueBranch_o;
  logic [OPCODE_W-1:0]   issueOpcode_o;
  logic [REG_W-1:0]      issuePrim_o;
  logic [OPERAND_W-1:0]  issueSec_o;
  logic                  wbValid_i;
  logic [REG_W-1:0]      wbReg_i;
  logic                  branchResolved_i;
  sched_state_t          dbg_state_o;
  logic [NUM_REGS-1:0]   dbg_busy_o;
  logic [INFLIGHT_W-1:0] dbg_inflight_o;

  issue_scheduler dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .format_i(format_i),
    .isBranch_i(isBranch_i), .opcode_i(opcode_i), .primOperand_i(primOperand_i),
    .secOperand_i(secOperand_i), .shouldStalled_o(shouldStalled_o),
    .issueValid_o(issueValid_o), .issueReady_i(issueReady_i),
    .issueFormat_o(issueFormat_o), .issueBranch_o(issueBranch_o),
    .issueOpcode_o(issueOpcode_o), .issuePrim_o(issuePrim_o), .issueSec_o(issueSec_o),
    .wbValid_i(wbValid_i), .wbReg_i(wbReg_i), .branchResolved_i(branchResolved_i),
    .dbg_state_o(dbg_state_o), .dbg_busy_o(dbg_busy_o), .dbg_inflight_o(dbg_inflight_o)
  );

  always #5 clock_i = ~clock_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: hold as a 0/1-entry queue, plain busy array and counters.
  parsed_instr_t m_hold[$];
  bit            m_slot_valid;
  parsed_instr_t m_slot;
  bit            m_busy[NUM_REGS];
  int            m_inflight;
  bit            m_wait;
  logic [IW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_idle();
    enable_i = 0; format_i = 0; isBranch_i = 0; opcode_i = '0;
    primOperand_i = '0; secOperand_i = '0;
    wbValid_i = 0; wbReg_i = '0; branchResolved_i = 0;
  endtask

  task automatic drive(input bit fmt, input bit br, input int prim, input int sec);
    enable_i = 1; format_i = fmt; isBranch_i = br;
    opcode_i = OPCODE_W'($urandom_range(0, 127));
    primOperand_i = REG_W'(prim); secOperand_i = OPERAND_W'(sec);
  endtask

  task automatic model_clear();
    m_hold.delete(); exp_q.delete();
    m_slot_valid = 0; m_slot = '0; m_inflight = 0; m_wait = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
  endtask

  task automatic do_reset();
    reset_i = 1;
    @(posedge clock_i);
    @(negedge clock_i);
    model_clear();
    reset_i = 0;
  endtask

  // One clock: compare DUT to model, then advance the model across the edge.
  task automatic step();
    parsed_instr_t h, inp;
    bit can, accept, stall_m;
    logic [31:0] busy_vec;
    #1;
    can = 0;
    h = '0;
    if (m_hold.size() > 0) begin
      h = m_hold[0];
      can = !(m_busy[h.prim] || (!h.format && m_busy[h.sec[REG_W-1:0]])) &&
            (!m_slot_valid || issueReady_i) && (h.is_branch || m_inflight < MAX_INFLIGHT) &&
            !m_wait;
    end
    stall_m = m_wait || (m_hold.size() > 0 && (!can || h.is_branch));
    busy_vec = '0;
    foreach (m_busy[i]) busy_vec[i] = m_busy[i];
    check("stall", shouldStalled_o, stall_m);
    check("issue_valid", issueValid_o, m_slot_valid);
    if (m_slot_valid)
      check("issue_fields", {issueFormat_o, issueBranch_o, issueOpcode_o, issuePrim_o, issueSec_o}, m_slot);
    check("busy", dbg_busy_o, busy_vec);
    check("inflight", dbg_inflight_o, m_inflight);
    check("state", dbg_state_o, m_wait);
    if (issueValid_o && issueReady_i) begin
      if (exp_q.size() == 0) check("issue_unexpected", 1, 0);
      else check("issue_order", {issueFormat_o, issueBranch_o, issueOpcode_o, issuePrim_o, issueSec_o},
                 exp_q.pop_front());
    end
    accept = enable_i && !stall_m;
    inp = '{format: format_i, is_branch: isBranch_i, opcode: opcode_i,
            prim: primOperand_i, sec: secOperand_i};
    @(posedge clock_i);
    if (m_wait && branchResolved_i) m_wait = 0;
    if (wbValid_i) begin
      m_busy[wbReg_i] = 0;
      if (!(can && !h.is_branch) && m_inflight > 0) m_inflight--;
    end
    if (can) begin
      void'(m_hold.pop_front());
      m_slot = h; m_slot_valid = 1;
      exp_q.push_back(h);
      if (h.is_branch) m_wait = 1;
      else begin
        m_busy[h.prim] = 1;
        if (!wbValid_i) m_inflight++;
      end
    end else if (issueReady_i) begin
      m_slot_valid = 0;
    end
    if (accept) m_hold.push_back(inp);
    @(negedge clock_i);
  endtask

  typedef struct {
    bit en, fmt;
    int prim, sec;
    bit ready, wbv;
    int wbreg;
    bit exp_stall, exp_valid;
    int exp_prim;
  } vec_t;
  vec_t vecs[8];

  initial begin
    set_idle();
    issueReady_i = 1;
    reset_i = 1;
    @(negedge clock_i);
    do_reset();

    // Independent ops, then a RAW hazard on r4 released by a writeback.
    vecs[0] = '{1, 1, 1, 5, 1, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 2, 3, 1, 0, 0, 0, 0, 0};
    vecs[2] = '{1, 1, 4, 0, 1, 0, 0, 0, 1, 1};
    vecs[3] = '{1, 0, 5, 4, 1, 0, 0, 0, 1, 2};
    vecs[4] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 4};
    vecs[5] = '{0, 0, 0, 0, 1, 1, 4, 1, 0, 0};
    vecs[6] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[7] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 5};
    check("reset_valid", issueValid_o, 0);
    check("reset_stall", shouldStalled_o, 0);
    check("reset_fields", {issueFormat_o, issueBranch_o, issueOpcode_o, issuePrim_o, issueSec_o}, 0);
    for (int i = 0; i < 8; i++) begin
      set_idle();
      if (vecs[i].en) drive(vecs[i].fmt, 0, vecs[i].prim, vecs[i].sec);
      issueReady_i = vecs[i].ready;
      wbValid_i = vecs[i].wbv;
      wbReg_i = REG_W'(vecs[i].wbreg);
      #1;
      check($sformatf("vec%0d_stall", i), shouldStalled_o, vecs[i].exp_stall);
      check($sformatf("vec%0d_valid", i), issueValid_o, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_prim", i), issuePrim_o, vecs[i].exp_prim);
      step();
    end
    set_idle();
    check("vec_busy", dbg_busy_o, 32'h26);
    check("vec_inflight", dbg_inflight_o, 3);

    // Branch serialisation.
    do_reset();
    issueReady_i = 1;
    drive(1, 1, 0, 0);
    step();
    drive(1, 0, 9, 0);
    for (int i = 0; i < 5; i++) begin
      #1 check("br_stall", shouldStalled_o, 1);
      step();
    end
    check("br_state", dbg_state_o, BRANCH_WAIT);
    check("br_busy", dbg_busy_o, 0);
    branchResolved_i = 1;
    #1 check("br_resolve_stall", shouldStalled_o, 1);
    step();
    branchResolved_i = 0;
    #1 check("br_after_stall", shouldStalled_o, 0);
    step();
    set_idle();
    step();
    step();
    check("br_busy_after", dbg_busy_o, 32'h200);

    // Writer limit and simultaneous fire/writeback.
    do_reset();
    issueReady_i = 1;
    for (int r = 10; r < 15; r++) begin
      drive(1, 0, r, 0);
      step();
    end
    drive(1, 0, 15, 0);
    #1 check("lim_stall", shouldStalled_o, 1);
    check("lim_inflight", dbg_inflight_o, 4);
    step();
    wbValid_i = 1; wbReg_i = 10;
    step();
    wbValid_i = 0;
    #1 check("lim_release", shouldStalled_o, 0);
    step();
    set_idle();
    wbValid_i = 1; wbReg_i = 11;
    #1 check("lim_block2", shouldStalled_o, 1);
    step();
    wbValid_i = 1; wbReg_i = 12;
    #1 check("lim_fire_wb", shouldStalled_o, 0);
    step();
    wbValid_i = 0;
    check("lim_inflight_same", dbg_inflight_o, 3);
    step();

    // Backpressure on the issue slot.
    do_reset();
    issueReady_i = 0;
    drive(1, 0, 16, 0);
    step();
    drive(1, 0, 17, 0);
    step();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_stall", shouldStalled_o, 1);
      check("bp_prim", issuePrim_o, 16);
      step();
    end
    issueReady_i = 1;
    #1 check("bp_drain_stall", shouldStalled_o, 0);
    step();
    check("bp_second", issuePrim_o, 17);
    check("bp_second_valid", issueValid_o, 1);
    step();

    // Reset while waiting on a branch with r7 busy.
    do_reset();
    issueReady_i = 1;
    drive(1, 0, 7, 0);
    step();
    drive(1, 1, 0, 0);
    step();
    set_idle();
    step();
    check("rst_pre_state", dbg_state_o, BRANCH_WAIT);
    check("rst_pre_busy7", dbg_busy_o[7], 1);
    do_reset();
    #1 check("rst_valid", issueValid_o, 0);
    check("rst_stall", shouldStalled_o, 0);
    check("rst_fields", {issueFormat_o, issueBranch_o, issueOpcode_o, issuePrim_o, issueSec_o}, 0);
    check("rst_busy", dbg_busy_o, 0);
    drive(0, 0, 8, 7);
    step();
    set_idle();
    #1 check("rst_issue_stall", shouldStalled_o, 0);
    step();
    check("rst_issue_valid", issueValid_o, 1);
    check("rst_issue_prim", issuePrim_o, 8);

    // Randomized traffic on a small register window to provoke hazards.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      set_idle();
      if ($urandom_range(0, 3) != 0)
        drive($urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom_range(0, 7),
              {$urandom_range(0, 2047), 5'($urandom_range(0, 7))});
      issueReady_i = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 2) == 0) begin
        wbValid_i = 1;
        wbReg_i = REG_W'($urandom_range(0, 7));
      end
      branchResolved_i = (m_wait && $urandom_range(0, 3) == 0) || $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end
    set_idle();
    check("final_exp_q", exp_q.size(), m_slot_valid ? 1 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
